// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix stream driver: widths, the FSM state
// encoding and a helper that qualifies a requested dimension.
package matrix_pkg;

    localparam int DW      = 8;
    localparam int MAX_DIM = 4;
    localparam int AW      = 4;
    localparam int HDR_LEN = 3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        SEND_DIM  = 3'd2,
        SEND_A    = 3'd3,
        SEND_B    = 3'd4,
        WAIT_DONE = 3'd5,
        COLLECT   = 3'd6,
        FINISH    = 3'd7
    } state_e;

    function automatic logic dim_ok(input logic [2:0] d, input int max_dim);
        dim_ok = (d != 3'd0) && (int'(d) <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_buf.sv
// Element buffer: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; out-of-range accesses are ignored.
module matrix_buf #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Storage write.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read, zero for addresses beyond the array.
    always_comb begin
        rdata = (int'(raddr) < DEPTH) ? mem[raddr] : {DW{1'b0}};
    end

endmodule

// File: rtl/matrix_stream_driver.sv
// Streams dimensions and A/B operands to a serial matrix multiplier and
// collects its serial result stream into a readable result buffer.
module matrix_stream_driver #(
    parameter int DW      = matrix_pkg::DW,
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int AW      = matrix_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    cfg_m,
    input  logic [2:0]    cfg_n,
    input  logic [2:0]    cfg_p,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          go,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          mm_start,
    output logic [DW-1:0] mm_in_data,
    input  logic          mm_done,
    input  logic [DW-1:0] mm_out_data,
    input  logic          mm_overflow,
    output logic          busy,
    output logic          complete,
    output logic          ovf_flag,
    output logic          cfg_err
);
    import matrix_pkg::*;

    localparam int DEPTH = MAX_DIM * MAX_DIM;
    localparam int CW    = AW + 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      m_q, m_d, n_q, n_d, p_q, p_d;
    logic            busy_q, busy_d;
    logic            complete_q, complete_d;
    logic            mm_start_q, mm_start_d;
    logic            cfg_err_q, cfg_err_d;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   data_q, data_d;

    logic [5:0]      len_a, len_b, len_c;
    logic            go_ok;
    logic            host_wr;
    logic            a_we, b_we, res_we;
    logic [AW-1:0]   res_waddr;
    logic [AW-1:0]   op_raddr;
    logic [DW-1:0]   a_rdata, b_rdata;

    // Host writes land only while idle; result writes follow the capture window.
    always_comb begin
        host_wr   = wr_en && (state_q == IDLE);
        a_we      = host_wr && !wr_sel;
        b_we      = host_wr && wr_sel;
        res_we    = ((state_q == WAIT_DONE) && mm_done) || (state_q == COLLECT);
        res_waddr = (state_q == COLLECT) ? cnt_q[AW-1:0] : {AW{1'b0}};
    end

    // Next-state, counters and the next value of every registered output.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        n_d        = n_q;
        p_d        = p_q;
        cfg_err_d  = 1'b0;
        len_a      = 6'(m_q) * 6'(n_q);
        len_b      = 6'(n_q) * 6'(p_q);
        len_c      = 6'(m_q) * 6'(p_q);
        go_ok      = go && dim_ok(cfg_m, MAX_DIM) && dim_ok(cfg_n, MAX_DIM)
                        && dim_ok(cfg_p, MAX_DIM);

        case (state_q)
            IDLE: begin
                if (go_ok) begin
                    state_d = START;
                    m_d     = cfg_m;
                    n_d     = cfg_n;
                    p_d     = cfg_p;
                end else if (go) begin
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                state_d = SEND_DIM;
                cnt_d   = {CW{1'b0}};
            end
            SEND_DIM: begin
                if (6'(cnt_q) == 6'(HDR_LEN - 1)) begin
                    state_d = SEND_A;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND_A: begin
                if (6'(cnt_q) == len_a - 6'd1) begin
                    state_d = SEND_B;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SEND_B: begin
                if (6'(cnt_q) == len_b - 6'd1) begin
                    state_d = WAIT_DONE;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                // The done cycle itself carries result element 0.
                if (mm_done) begin
                    state_d = (len_c == 6'd1) ? FINISH : COLLECT;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            COLLECT: begin
                if (6'(cnt_q) == len_c - 6'd1) begin
                    state_d = FINISH;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase

        mm_start_d = (state_d == START);
        busy_d     = (state_d != IDLE) && (state_d != FINISH);
        complete_d = (state_d == FINISH);
        op_raddr   = cnt_d[AW-1:0];

        case (state_d)
            SEND_DIM: begin
                case (cnt_d)
                    CW'(0):  data_d = DW'(m_q);
                    CW'(1):  data_d = DW'(n_q);
                    default: data_d = DW'(p_q);
                endcase
            end
            SEND_A:  data_d = a_rdata;
            SEND_B:  data_d = b_rdata;
            default: data_d = {DW{1'b0}};
        endcase

        if ((state_q == IDLE) && go_ok) begin
            ovf_d = 1'b0;
        end else if (busy_q && mm_overflow) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= {CW{1'b0}};
            m_q        <= 3'd0;
            n_q        <= 3'd0;
            p_q        <= 3'd0;
            busy_q     <= 1'b0;
            complete_q <= 1'b0;
            mm_start_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            ovf_q      <= 1'b0;
            data_q     <= {DW{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            n_q        <= n_d;
            p_q        <= p_d;
            busy_q     <= busy_d;
            complete_q <= complete_d;
            mm_start_q <= mm_start_d;
            cfg_err_q  <= cfg_err_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
        end
    end

    assign busy       = busy_q;
    assign complete   = complete_q;
    assign mm_start   = mm_start_q;
    assign cfg_err    = cfg_err_q;
    assign ovf_flag   = ovf_q;
    assign mm_in_data = data_q;

    matrix_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_buf_a (
        .clk(clk), .we(a_we), .waddr(wr_addr), .wdata(wr_data),
        .raddr(op_raddr), .rdata(a_rdata)
    );

    matrix_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_buf_b (
        .clk(clk), .we(b_we), .waddr(wr_addr), .wdata(wr_data),
        .raddr(op_raddr), .rdata(b_rdata)
    );

    matrix_buf #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_buf_res (
        .clk(clk), .we(res_we), .waddr(res_waddr), .wdata(mm_out_data),
        .raddr(rd_addr), .rdata(rd_data)
    );

endmodule

// File: tb/tb_matrix_stream_driver.sv
// Randomized bench: the bench plays the multiplier and holds a plain
// array-based model of the operands, expected stream and products.
module tb_matrix_stream_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] cfg_m = 3'd0, cfg_n = 3'd0, cfg_p = 3'd0;
    logic       wr_en = 1'b0, wr_sel = 1'b0;
    logic [3:0] wr_addr = 4'd0;
    logic [7:0] wr_data = 8'd0;
    logic       go = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       mm_start;
    logic [7:0] mm_in_data;
    logic       mm_done = 1'b0;
    logic [7:0] mm_out_data = 8'd0;
    logic       mm_overflow = 1'b0;
    logic       busy, complete, ovf_flag, cfg_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [7:0] a_m [16];
    logic [7:0] b_m [16];

    matrix_stream_driver dut (
        .clk(clk), .rst(rst), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_p(cfg_p),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go), .rd_addr(rd_addr), .rd_data(rd_data), .mm_start(mm_start),
        .mm_in_data(mm_in_data), .mm_done(mm_done), .mm_out_data(mm_out_data),
        .mm_overflow(mm_overflow), .busy(busy), .complete(complete),
        .ovf_flag(ovf_flag), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_elem(input bit sel, input int addr, input logic [7:0] val);
        wr_en = 1'b1; wr_sel = sel; wr_addr = 4'(addr); wr_data = val;
        tick();
        wr_en = 1'b0;
        if (sel) b_m[addr] = val; else a_m[addr] = val;
    endtask

    // Plain matrix product truncated to the stream width.
    function automatic logic [7:0] prod(input int m, input int n, input int p, input int idx);
        int i, j, s;
        i = idx / p; j = idx % p; s = 0;
        for (int k = 0; k < n; k++) s += int'(a_m[i*n+k]) * int'(b_m[k*p+j]);
        return 8'(s);
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_complete"}, complete, 0);
        chk({tag, "_cfg_err"}, cfg_err, 0);
        chk({tag, "_ovf"}, ovf_flag, 0);
        chk({tag, "_mm_start"}, mm_start, 0);
        chk({tag, "_mm_in_data"}, mm_in_data, 0);
    endtask

    task automatic run_mult(input int m, input int n, input int p, input int w,
                            input bit ovf_pulse, input bit poke, input bit same_wr);
        logic [7:0] exp_q [$];
        logic [7:0] c [16];
        int t0, g;
        if (same_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'($urandom);
            a_m[0] = wr_data;
        end
        cfg_m = 3'(m); cfg_n = 3'(n); cfg_p = 3'(p); go = 1'b1;
        exp_q = '{8'(m), 8'(n), 8'(p)};
        for (int i = 0; i < m*n; i++) exp_q.push_back(a_m[i]);
        for (int i = 0; i < n*p; i++) exp_q.push_back(b_m[i]);
        for (int i = 0; i < m*p; i++) c[i] = prod(m, n, p, i);
        t0 = cyc;
        tick();
        go = 1'b0; wr_en = 1'b0;
        chk("mm_start_pulse", mm_start, 1);
        chk("busy_after_go", busy, 1);
        chk("ovf_cleared_by_go", ovf_flag, 0);
        chk("start_data_zero", mm_in_data, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            tick();
            chk("stream", mm_in_data, exp_q[k]);
            if (k == 0) chk("mm_start_one_cycle", mm_start, 0);
        end
        tick();
        chk("data_zero_after_b", mm_in_data, 0);
        for (int wi = 0; wi < w; wi++) begin
            if (ovf_pulse && wi == 0) mm_overflow = 1'b1;
            if (poke && wi == 0) begin
                go = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = ~a_m[0];
            end
            tick();
            mm_overflow = 1'b0; go = 1'b0; wr_en = 1'b0;
        end
        mm_done = 1'b1; mm_out_data = c[0];
        for (int i = 1; i < m*p; i++) begin
            tick();
            mm_done = 1'b0; mm_out_data = c[i];
        end
        tick();
        mm_done = 1'b0; mm_out_data = 8'd0;
        g = 0;
        while (!complete && g < 40) begin
            tick();
            g++;
        end
        chk("complete_seen", complete, 1);
        chk("latency", cyc - t0, 5 + m*n + n*p + w + m*p);
        chk("busy_low_at_complete", busy, 0);
        tick();
        chk("complete_one_cycle", complete, 0);
        chk("ovf_after_run", ovf_flag, ovf_pulse ? 1 : 0);
        for (int i = 0; i < m*p; i++) begin
            rd_addr = 4'(i);
            #1;
            chk("result", rd_data, c[i]);
        end
    endtask

    initial begin
        int m, n, p, w, err_seen;
        bit ov;
        repeat (2) tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Directed 2x2x2 product.
        for (int i = 0; i < 4; i++) write_elem(1'b0, i, 8'(i + 1));
        for (int i = 0; i < 4; i++) write_elem(1'b1, i, 8'(i + 5));
        run_mult(2, 2, 2, 2, 1'b0, 1'b0, 1'b0);
        chk("r00_19", prod(2, 2, 2, 0), 19);
        chk("r11_50", prod(2, 2, 2, 3), 50);

        // Invalid dimensions: zero and above the maximum.
        for (int t = 0; t < 2; t++) begin
            cfg_m = (t == 0) ? 3'd0 : 3'd5; cfg_n = 3'd2; cfg_p = 3'd2; go = 1'b1;
            tick();
            go = 1'b0;
            chk("cfg_err_pulse", cfg_err, 1);
            chk("cfg_err_no_start", mm_start, 0);
            chk("cfg_err_not_busy", busy, 0);
            tick();
            chk("cfg_err_one_cycle", cfg_err, 0);
            chk("cfg_err_still_idle", busy, 0);
        end

        // Overflow during WAIT_DONE, then cleared by the next go.
        run_mult(2, 2, 2, 3, 1'b1, 1'b0, 1'b0);
        run_mult(1, 2, 1, 1, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of SEND_A.
        cfg_m = 3'd2; cfg_n = 3'd2; cfg_p = 3'd2; go = 1'b1;
        tick();
        go = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        tick();
        rst = 1'b0;
        err_seen = 0;
        repeat (30) begin
            tick();
            if (complete || busy || mm_in_data != 8'd0) err_seen = 1;
        end
        chk("no_activity_after_abort", err_seen, 0);
        run_mult(2, 2, 2, 0, 1'b0, 1'b0, 1'b0);

        // 1x1x1 with done right after the last byte.
        write_elem(1'b0, 0, 8'd7);
        write_elem(1'b1, 0, 8'd9);
        run_mult(1, 1, 1, 0, 1'b0, 1'b0, 1'b0);
        chk("r_1x1_63", prod(1, 1, 1, 0), 63);

        // go and wr_en while busy are ignored; the next run shows A unchanged.
        run_mult(2, 3, 2, 2, 1'b0, 1'b1, 1'b0);
        run_mult(2, 3, 2, 0, 1'b0, 1'b0, 1'b0);

        // Write in the same cycle as go is streamed.
        run_mult(3, 2, 1, 1, 1'b0, 1'b0, 1'b1);

        // Random configurations and contents.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) write_elem(1'b0, i, 8'($urandom));
            for (int i = 0; i < 16; i++) write_elem(1'b1, i, 8'($urandom));
            m = $urandom_range(4, 1); n = $urandom_range(4, 1); p = $urandom_range(4, 1);
            w = $urandom_range(3, 0);
            ov = (w > 0) && ($urandom_range(1, 0) == 1);
            run_mult(m, n, p, w, ov, 1'b0, ($urandom_range(3, 0) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
